mem_arbiter: RTL

Shares one synchronous single-port SRAM between the CPU instruction-fetch (IM) and data (DM) interfaces. Sits between the CPU core and a unified memory macro, replacing the separate IM/DM memories. Arbitrates per access, drives the SRAM port and returns data with a req/ready handshake. Exports a stall that the CPU hazard logic ORs into its pipeline freeze.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port SRAM between the CPU
// instruction-fetch (IM) and data (DM) interfaces using req/ready handshakes.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   im_req, im_addr                fetch request / address (held until im_ready)
//   im_rdata, im_ready             fetch data (held) and one-cycle completion pulse
//   dm_req, dm_we, dm_addr,        data request, write flag, address, write data
//   dm_wdata                       (held until dm_ready)
//   dm_rdata, dm_ready             read data (held, untouched by writes), completion pulse
//   mem_en, mem_we, mem_addr,      SRAM port, driven combinationally from the grant
//   mem_wdata
//   mem_rdata                      SRAM read data, valid one cycle after mem_en
//   cpu_stall                      pipeline freeze request
//
// Build option: define MEM_ARB_RR_EN to replace DM priority with starvation
// relief by an alternating last-winner grant on conflicts.
//
// Access timing per requester: grant in cycle N (SRAM port driven), GRANTED in
// N+1 (SRAM data captured), DONE in N+2 (ready pulse). A requester is only
// eligible from IDLE, so a held req is never re-granted with a stale address.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_DONE    = 2'd2
  } req_state_t;

  req_state_t im_state, im_state_nxt;
  req_state_t dm_state, dm_state_nxt;

  logic im_elig_c, dm_elig_c;
  logic im_gnt_c, dm_gnt_c;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic dm_rd_pend;

`ifdef MEM_ARB_RR_EN
  logic rr_last_im;
`else
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;
`endif

  // State register for both requester FSMs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_state <= S_IDLE;
      dm_state <= S_IDLE;
    end else begin
      im_state <= im_state_nxt;
      dm_state <= dm_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    im_state_nxt = im_state;
    dm_state_nxt = dm_state;
    case (im_state)
      S_IDLE:    if (im_gnt_c) im_state_nxt = S_GRANTED;
      S_GRANTED: im_state_nxt = S_DONE;
      default:   im_state_nxt = S_IDLE;
    endcase
    case (dm_state)
      S_IDLE:    if (dm_gnt_c) dm_state_nxt = S_GRANTED;
      S_GRANTED: dm_state_nxt = S_DONE;
      default:   dm_state_nxt = S_IDLE;
    endcase
  end

  // Grant decision and SRAM port; nothing is granted while reset is asserted
  always_comb begin
    im_elig_c = rst & im_req & (im_state == S_IDLE);
    dm_elig_c = rst & dm_req & (dm_state == S_IDLE);
    im_gnt_c  = im_elig_c;
    dm_gnt_c  = dm_elig_c;
    if (im_elig_c && dm_elig_c) begin
`ifdef MEM_ARB_RR_EN
      im_gnt_c = ~rr_last_im;
`else
      im_gnt_c = (starve_cnt == CNT_W'(STARVE_MAX));
`endif
      dm_gnt_c = ~im_gnt_c;
    end
    mem_en    = im_gnt_c | dm_gnt_c;
    mem_we    = dm_gnt_c & dm_we;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    // Only the granted requester's inputs reach the SRAM port
    if (dm_gnt_c) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (im_gnt_c) begin
      mem_addr  = im_addr;
    end
    cpu_stall = rst & ((im_req & ~im_ready) | (dm_req & ~dm_ready));
  end

  // Registered outputs, data capture and arbitration history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_rdata   <= '0;
      im_ready   <= 1'b0;
      dm_rdata   <= '0;
      dm_ready   <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      dm_rd_pend <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_im <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
      im_ready   <= (im_state == S_GRANTED);
      dm_ready   <= (dm_state == S_GRANTED);
      if (im_state == S_GRANTED) im_rdata <= mem_rdata;
      if (dm_state == S_GRANTED && dm_rd_pend) dm_rdata <= mem_rdata;
      if (dm_gnt_c) dm_rd_pend <= ~dm_we;
`ifdef MEM_ARB_RR_EN
      if (im_elig_c && dm_elig_c) rr_last_im <= im_gnt_c;
`else
      if (im_gnt_c) begin
        starve_cnt <= '0;
      end else if (im_elig_c && dm_gnt_c && starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule
